// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter.
// One transaction at a time walks IDLE -> ACCESS -> RESP. When both requesters
// ask together, round-robin arbitration gives the grant to the one not served last.
// Misaligned word accesses are flagged back to the requester and never reach memory.
// Every output is a register. This keeps the memory side free of glitches and
// makes the ack a clean one-cycle pulse.

module dmem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,

  // Requester 0
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_byte,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,

  // Requester 1
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_byte,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,

  // Data memory side. 'byte' is a reserved word, hence mem_byte.
  output logic              MemRead,
  output logic              MemWrite,
  output logic              mem_byte,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data,

  output logic              busy
);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

  state_e state_q;

  // Id of the requester served by the most recent completed transaction.
  // A value of 1 means m1 was served last, so m0 gets priority.
  logic last_q;
  // Id of the requester whose transaction is in flight.
  logic win_q;
  // The in-flight transaction is a misaligned word access.
  logic mis_q;

  // Combinational selection of the requester that wins at the next IDLE edge
  logic              sel_win;
  logic              sel_we;
  logic              sel_byte;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_mis;
  logic [DATA_W-1:0] resp_data;

  // Pick the winner and its request fields. Under contention, m1 wins only if m0 was served last.
  always_comb begin
    sel_win   = m1_req & (~m0_req | ~last_q);
    sel_we    = sel_win ? m1_we    : m0_we;
    sel_byte  = sel_win ? m1_byte  : m0_byte;
    sel_addr  = sel_win ? m1_addr  : m0_addr;
    sel_wdata = sel_win ? m1_wdata : m0_wdata;
    sel_mis   = ~sel_byte & (sel_addr[1:0] != 2'b00);
    // MemRead is high only for an aligned read, so writes and faults return zero.
    resp_data = MemRead ? read_data : '0;
  end

  // Transaction FSM. All outputs are registered in this block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      last_q     <= 1'b1;
      win_q      <= 1'b0;
      mis_q      <= 1'b0;
      MemRead    <= 1'b0;
      MemWrite   <= 1'b0;
      mem_byte   <= 1'b0;
      address    <= '0;
      write_data <= '0;
      m0_ack     <= 1'b0;
      m0_rdata   <= '0;
      m0_err     <= 1'b0;
      m1_ack     <= 1'b0;
      m1_rdata   <= '0;
      m1_err     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (m0_req || m1_req) begin
            // Latch the winner's request. Later input changes do not affect this transaction.
            win_q      <= sel_win;
            mis_q      <= sel_mis;
            MemRead    <= ~sel_we & ~sel_mis;
            MemWrite   <= sel_we & ~sel_mis;
            mem_byte   <= sel_byte;
            address    <= sel_addr;
            write_data <= sel_wdata;
            busy       <= 1'b1;
            state_q    <= StAccess;
          end
        end

        StAccess: begin
          MemRead    <= 1'b0;
          MemWrite   <= 1'b0;
          mem_byte   <= 1'b0;
          address    <= '0;
          write_data <= '0;
          m0_ack     <= ~win_q;
          m1_ack     <= win_q;
          m0_rdata   <= win_q ? '0 : resp_data;
          m1_rdata   <= win_q ? resp_data : '0;
          m0_err     <= ~win_q & mis_q;
          m1_err     <= win_q & mis_q;
          state_q    <= StResp;
        end

        StResp: begin
          m0_ack   <= 1'b0;
          m0_rdata <= '0;
          m0_err   <= 1'b0;
          m1_ack   <= 1'b0;
          m1_rdata <= '0;
          m1_err   <= 1'b0;
          last_q   <= win_q;
          busy     <= 1'b0;
          state_q  <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
